// File: rtl/deadlock_block_watchdog_pkg.sv
// Shared types and helpers for the deadlock block watchdog: FSM encoding,
// default persistence threshold and a saturating increment.
package deadlock_block_watchdog_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_TRIP  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam int DEFAULT_THRESHOLD = 16;

   // Widths up to 32 bits; callers cast in and out.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/deadlock_block_watchdog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module deadlock_block_watchdog_sat_counter
   import deadlock_block_watchdog_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_q
);

   localparam logic [W-1:0] MAX_V = {W{1'b1}};

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_q <= '0;
      end else if (i_inc) begin
         r_q <= W'(sat_inc(32'(r_q), 32'(MAX_V)));
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/deadlock_block_watchdog.sv
// Confirms a kernel deadlock when block_in persists with a stable blocked-channel
// pattern for THRESHOLD cycles, then latches a snapshot until cleared.
module deadlock_block_watchdog
   import deadlock_block_watchdog_pkg::*;
#(
   parameter int N_AXIS    = 2,
   parameter int N_INST    = 3,
   parameter int THRESHOLD = DEFAULT_THRESHOLD,
   parameter int CNT_W     = 8
) (
   input  logic              kernel_monitor_clock,
   input  logic              kernel_monitor_reset,
   input  logic              block_in,
   input  logic [N_AXIS-1:0] axis_block_sigs,
   input  logic [N_INST-1:0] inst_idle_sigs,
   input  logic              clear,
   output logic              deadlock_pulse,
   output logic              deadlock_sticky,
   output logic [N_AXIS-1:0] axis_snapshot,
   output logic [N_INST-1:0] idle_snapshot,
   output logic [CNT_W-1:0]  hold_cycles,
   output logic [7:0]        trip_count,
   output logic [1:0]        dbg_state
);

   // No valid/ready handshake here: block_in and the signal vectors are level
   // inputs sampled every cycle, clear is a level acknowledge honoured only in S_HOLD.

   localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [N_AXIS-1:0] r_pattern;
   logic [N_INST-1:0] r_idle_q;
   logic              w_load;
   logic              w_cap;
   logic              w_pat_eq;
   logic              r_sticky;
   logic [N_AXIS-1:0] r_axis_snap;
   logic [N_INST-1:0] r_idle_snap;
   logic              w_hold_inc;
   logic              w_hold_clr;
   logic              w_trip_inc;

   assign w_pat_eq  = (axis_block_sigs == r_pattern);
   assign w_cnt_inc = r_cnt + ONE;

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_load    = 1'b0;
      w_cap     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (block_in) begin
               w_load    = 1'b1;
               w_cap     = 1'b1;
               w_cnt_nxt = ONE;
               w_next    = (THRESHOLD == 1) ? S_TRIP : S_COUNT;
            end else begin
               w_cnt_nxt = '0;
            end
         end
         S_COUNT: begin
            if (!block_in) begin
               w_next    = S_IDLE;
               w_cnt_nxt = '0;
            end else if (!w_pat_eq) begin
               w_load    = 1'b1;
               w_cap     = 1'b1;
               w_cnt_nxt = ONE;
            end else begin
               w_cap     = 1'b1;
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == THR) w_next = S_TRIP;
            end
         end
         S_TRIP: begin
            w_next    = S_HOLD;
            w_cnt_nxt = '0;
         end
         S_HOLD: begin
            if (clear) w_next = S_IDLE;
         end
         default: begin
            w_next    = S_IDLE;
            w_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_pattern   <= '0;
         r_idle_q    <= '0;
         r_sticky    <= 1'b0;
         r_axis_snap <= '0;
         r_idle_snap <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         if (w_load) r_pattern <= axis_block_sigs;
         if (w_cap)  r_idle_q  <= inst_idle_sigs;
         // Snapshot comes from the pattern registered on the entering edge.
         if (r_state == S_TRIP) begin
            r_sticky    <= 1'b1;
            r_axis_snap <= r_pattern;
            r_idle_snap <= r_idle_q;
         end else if (r_state == S_HOLD && clear) begin
            r_sticky    <= 1'b0;
            r_axis_snap <= '0;
            r_idle_snap <= '0;
         end
      end
   end

   assign w_hold_inc = (r_state == S_HOLD) && !clear;
   assign w_hold_clr = (r_state == S_HOLD) && clear;
   assign w_trip_inc = (r_state == S_TRIP);

   deadlock_block_watchdog_sat_counter #(.W(CNT_W)) u_hold_cnt (
      .i_clk (kernel_monitor_clock),
      .i_rst (kernel_monitor_reset),
      .i_inc (w_hold_inc),
      .i_clr (w_hold_clr),
      .o_q   (hold_cycles)
   );

   deadlock_block_watchdog_sat_counter #(.W(8)) u_trip_cnt (
      .i_clk (kernel_monitor_clock),
      .i_rst (kernel_monitor_reset),
      .i_inc (w_trip_inc),
      .i_clr (1'b0),
      .o_q   (trip_count)
   );

   assign deadlock_pulse  = (r_state == S_TRIP);
   assign deadlock_sticky = r_sticky;
   assign axis_snapshot   = r_axis_snap;
   assign idle_snapshot   = r_idle_snap;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_deadlock_block_watchdog.sv
// Directed bench for deadlock_block_watchdog at default parameters
// (THRESHOLD 16, CNT_W 8, N_AXIS 2, N_INST 3).
module tb_deadlock_block_watchdog;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       block_in = 1'b0;
   logic [1:0] axis_block_sigs = 2'b00;
   logic [2:0] inst_idle_sigs = 3'b000;
   logic       clear = 1'b0;
   logic       deadlock_pulse;
   logic       deadlock_sticky;
   logic [1:0] axis_snapshot;
   logic [2:0] idle_snapshot;
   logic [7:0] hold_cycles;
   logic [7:0] trip_count;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] exp_q[$];

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   deadlock_block_watchdog dut (
      .kernel_monitor_clock (clk),
      .kernel_monitor_reset (rst),
      .block_in             (block_in),
      .axis_block_sigs      (axis_block_sigs),
      .inst_idle_sigs       (inst_idle_sigs),
      .clear                (clear),
      .deadlock_pulse       (deadlock_pulse),
      .deadlock_sticky      (deadlock_sticky),
      .axis_snapshot        (axis_snapshot),
      .idle_snapshot        (idle_snapshot),
      .hold_cycles          (hold_cycles),
      .trip_count           (trip_count),
      .dbg_state            (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled and inputs changed 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Edges taken until the first pulse is seen; -1 if the budget runs out.
   task automatic wait_pulse(input int budget, output int edges);
      edges = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (deadlock_pulse) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic hold_then_clear();
      clear = 1'b0;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      int e;
      int bad;
      logic [1:0] exp_snap;

      // Reset
      repeat (3) step();
      check_eq("rst_state", dbg_state, ST_IDLE);
      check_eq("rst_pulse", deadlock_pulse, 0);
      check_eq("rst_sticky", deadlock_sticky, 0);
      check_eq("rst_axis_snap", axis_snapshot, 0);
      check_eq("rst_idle_snap", idle_snapshot, 0);
      check_eq("rst_hold", hold_cycles, 0);
      check_eq("rst_trip", trip_count, 0);
      rst = 1'b0;

      // Test 1: steady pattern 01, pulse after 16 edges
      exp_q.push_back(2'b01);
      block_in = 1'b1; axis_block_sigs = 2'b01; inst_idle_sigs = 3'b101;
      wait_pulse(40, e);
      check_eq("t1_latency", e, 16);
      step();
      exp_snap = exp_q.pop_front();
      check_eq("t1_state_hold", dbg_state, ST_HOLD);
      check_eq("t1_pulse_one_cycle", deadlock_pulse, 0);
      check_eq("t1_sticky", deadlock_sticky, 1);
      check_eq("t1_axis_snap", axis_snapshot, exp_snap);
      check_eq("t1_idle_snap", idle_snapshot, 3'b101);
      check_eq("t1_trip", trip_count, 1);
      check_eq("t1_hold0", hold_cycles, 0);
      block_in = 1'b0; axis_block_sigs = 2'b11; inst_idle_sigs = 3'b000;
      repeat (300) step();
      check_eq("t1_hold_sat", hold_cycles, 255);
      check_eq("t1_hold_sticky", deadlock_sticky, 1);
      check_eq("t1_hold_snap_kept", axis_snapshot, exp_snap);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_eq("t1_clr_state", dbg_state, ST_IDLE);
      check_eq("t1_clr_sticky", deadlock_sticky, 0);
      check_eq("t1_clr_hold", hold_cycles, 0);
      check_eq("t1_clr_snap", axis_snapshot, 0);
      check_eq("t1_clr_idle_snap", idle_snapshot, 0);
      check_eq("t1_clr_trip_kept", trip_count, 1);

      // Test 2: 10 blocked, 1 unblocked, then 16 more; clear during COUNT ignored
      block_in = 1'b1; axis_block_sigs = 2'b01; clear = 1'b1;
      repeat (10) step();
      check_eq("t2_state_count", dbg_state, ST_COUNT);
      check_eq("t2_no_pulse", deadlock_pulse, 0);
      clear = 1'b0; block_in = 1'b0;
      step();
      check_eq("t2_drop_idle", dbg_state, ST_IDLE);
      block_in = 1'b1;
      wait_pulse(40, e);
      check_eq("t2_latency", e, 16);
      // clear coincident with TRIP: HOLD is still entered
      clear = 1'b1;
      step();
      check_eq("t2_trip_clr_hold", dbg_state, ST_HOLD);
      check_eq("t2_trip_clr_sticky", deadlock_sticky, 1);
      step();
      clear = 1'b0;
      check_eq("t2_clr_idle", dbg_state, ST_IDLE);
      check_eq("t2_trip", trip_count, 2);

      // Test 3: pattern change 01 -> 10 after 8 edges restarts the count
      exp_q.push_back(2'b10);
      block_in = 1'b1; axis_block_sigs = 2'b01;
      repeat (8) step();
      axis_block_sigs = 2'b10;
      wait_pulse(40, e);
      check_eq("t3_latency", 8 + e, 24);
      step();
      check_eq("t3_axis_snap", axis_snapshot, exp_q.pop_front());
      check_eq("t3_trip", trip_count, 3);
      clear = 1'b1;
      step();
      clear = 1'b0;

      // Test 4: reset at counter 12 with block held
      axis_block_sigs = 2'b01;
      repeat (12) step();
      check_eq("t4_state_count", dbg_state, ST_COUNT);
      rst = 1'b1;
      step();
      check_eq("t4_rst_state", dbg_state, ST_IDLE);
      check_eq("t4_rst_pulse", deadlock_pulse, 0);
      check_eq("t4_rst_trip", trip_count, 0);
      rst = 1'b0;
      wait_pulse(40, e);
      check_eq("t4_latency", e, 16);
      hold_then_clear();

      // Test 5: 256 episodes saturate trip_count
      rst = 1'b1;
      step();
      rst = 1'b0;
      bad = 0;
      for (int ep = 0; ep < 256; ep++) begin
         wait_pulse(40, e);
         if (e != 16) bad++;
         hold_then_clear();
      end
      check_eq("t5_episode_latency", bad, 0);
      check_eq("t5_trip_sat", trip_count, 255);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
